and_or_pipe: RTL
================

// Module: and_or_pipe
// PURPOSE
//   Parametrised, pipelined, flow-controlled bitwise logic unit; next generation of our combinational AND-OR cell.
//   Computes one of four per-operand logic functions over WIDTH-bit vectors a, b, c.
//   Passes each result through STAGES registered stages with valid/ready handshakes on both sides.
//   Sits between a producer and a consumer that can each stall independently.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=1)
//   STAGES  2   pipeline depth in register stages (1..4); latency in cycles, accept to out_valid
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst_n      in   1      reset, asynchronous assert, active-low
//   in_valid   in   1      producer offers a/b/c/mode this cycle
//   in_ready   out  1      unit accepts this cycle (transfer = in_valid & in_ready)
//   mode       in   2      function select, sampled with operands at transfer
//   a, b, c    in   WIDTH  operands
//   out_valid  out  1      d/d_any hold a valid result
//   out_ready  in   1      consumer takes result (transfer = out_valid & out_ready)
//   d          out  WIDTH  result
//   d_any      out  1      |d, registered with d
// BEHAVIOUR
//   Function, per bit:
//   - mode 00: (a&b)|c
//   - mode 01: (a|b)&c
//   - mode 10: (a^b)|c
//   - mode 11: ~((a&b)|c)
//   - Computed combinationally at input, captured into stage 0 at transfer.
//   Reset (rst_n=0, async):
//   - All stage valid bits, d, d_any and out_valid clear to 0 immediately.
//   - In-flight data is discarded. No output on the first edge after release.
//   - in_ready is 1 whenever all stages are empty, including during reset.
//   Pipeline: stages s0..s(STAGES-1), each holding a valid bit plus WIDTH+1 data bits. The last stage drives d/d_any/out_valid.
//   - Stage k advances when v[k] & (k is last ? out_ready : ~v[k+1] | adv[k+1]).
//   - Stage k loads when it is empty or advancing.
//   - in_ready = ~v[0] | adv[0]. Combinational from out_ready through the chain; no comb path from in_valid.
//   - Latency: a transfer at edge N gives out_valid at edge N+STAGES-1. With STAGES=1, d is valid the cycle after transfer.
//   - Throughput: 1 result/cycle while out_ready=1.
//   - Bubbles collapse: an empty stage fills even while downstream is stalled.
//   Output stability: while out_valid=1 and out_ready=0, d and d_any do not change.
//   Ordering: results leave in acceptance order. No drops, no duplicates.
//   Full: all STAGES valid and out_ready=0 gives in_ready=0; in_valid is ignored.
//   Simultaneous events:
//   - Output transfer and input transfer in the same cycle when full is legal; occupancy is unchanged.
//   - Capacity is exactly STAGES entries.
//   - mode/a/b/c are don't-care when in_valid=0.
//   - The producer must hold in_valid (not required to hold data) until transfer.
// TESTING
//   1. WIDTH=8, STAGES=2, out_ready=1, mode=00, a=F0 b=3C c=01 -> d=31, d_any=1, out_valid 2 edges after accept.
//   2. Modes 01/10/11 with a=F0 b=3C c=0F -> d=0C / CF / C0. Then a=b=c=00 mode=00 -> d=00, d_any=0.
//   3. Stream 6 values, out_ready=0 -> accepts exactly 2, in_ready=0, d held. Release -> all 6 out in order, no gaps.
//   4. out_ready toggling 1010... with in_valid=1 continuous -> no loss or duplication; d stable while stalled.
//   5. Pull rst_n low with 2 results in flight -> out_valid=0, d=00 asynchronously. After release, first output is a new input.
//   6. STAGES=1 and STAGES=4, WIDTH=1 and WIDTH=32: latency equals STAGES; capacity equals STAGES under full stall.

Source files
------------

// File: rtl/and_or_pipe_if.sv
// Handshake bundle for and_or_pipe: producer side (in_*, operands) and consumer side (out_*, result).
interface and_or_pipe_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             d_any;

  modport master (
    output in_valid, mode, a, b, c, out_ready,
    input  in_ready, out_valid, d, d_any
  );

  modport slave (
    input  in_valid, mode, a, b, c, out_ready,
    output in_ready, out_valid, d, d_any
  );
endinterface

// File: rtl/and_or_pipe.sv
// Pipelined, flow-controlled bitwise logic unit: one of four AND/OR/XOR functions of a, b, c,
// carried through STAGES valid/ready register stages with bubble collapsing.
module and_or_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  and_or_pipe_if.slave   bus
);

  logic [WIDTH-1:0]  fn_res;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] src_v;
  logic              in_ready_c;
  logic [WIDTH:0]    data_q   [STAGES];
  logic [WIDTH:0]    data_d   [STAGES];
  logic [WIDTH:0]    src_data [STAGES];

  always_comb begin
    fn_res = '0;
    case (bus.mode)
      2'b00:   fn_res = (bus.a & bus.b) | bus.c;
      2'b01:   fn_res = (bus.a | bus.b) & bus.c;
      2'b10:   fn_res = (bus.a ^ bus.b) | bus.c;
      default: fn_res = ~((bus.a & bus.b) | bus.c);
    endcase
  end

  // Walk from the output back: a stage can take new data if it is empty or
  // everything downstream of it is moving, so in_ready depends on out_ready only.
  always_comb begin : flow
    logic nxt_free;
    nxt_free = bus.out_ready;
    adv      = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]   = v_q[k] & nxt_free;
      nxt_free = ~v_q[k] | nxt_free;
    end
    in_ready_c = nxt_free;
  end

  always_comb begin
    src_v       = '0;
    src_v[0]    = bus.in_valid;
    for (int k = 0; k < STAGES; k++) begin
      src_data[k] = '0;
    end
    src_data[0] = {|fn_res, fn_res};
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]    = adv[k-1];
      src_data[k] = data_q[k-1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
      if (~v_q[k] | adv[k]) begin
        v_d[k] = src_v[k];
        if (src_v[k]) begin
          data_d[k] = src_data[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.d         = data_q[STAGES-1][WIDTH-1:0];
  assign bus.d_any     = data_q[STAGES-1][WIDTH];

endmodule
